// File: rtl/jtopl_eg_pkg.sv
// jtopl_eg_pkg
// Shared definitions for the OPL envelope-generator slot sequencer:
// envelope state encodings, slot count, widths and reset values.
// Imported by jtopl_eg_ring and jtopl_eg_seq.
package jtopl_eg_pkg;

  localparam int SLOT_NUM = 18;
  localparam int SLOT_W   = 5;
  localparam int ST_W     = 3;
  localparam int EG_W     = 10;
  localparam int CNT_W    = 15;

  localparam logic [EG_W-1:0]   EG_MAX    = 10'h3FF;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 5'(SLOT_NUM - 1);

  // One-hot-ish encoding inherited from the original core; RELEASE is the
  // all-zero idle state so a cleared ring reads as "silent".
  typedef enum logic [ST_W-1:0] {
    RELEASE = 3'b000,
    ATTACK  = 3'b001,
    DECAY   = 3'b010,
    HOLD    = 3'b100
  } eg_state_t;

  // Slot successor. Anything at or past the last slot folds back to 0, so
  // an out-of-range value can never persist.
  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s);
    return (s >= SLOT_LAST) ? '0 : s + 5'd1;
  endfunction

endpackage

// File: rtl/jtopl_eg_ring.sv
// jtopl_eg_ring
// 18-entry per-slot storage ring. The entry selected by i_slot is read
// combinationally and overwritten on each cen edge, giving a zero-latency
// read-modify-write per slot. All other entries hold.
// Ports:
//   clk, rst   clock, async active-high reset (all entries -> RST_VAL)
//   i_cen      clock enable
//   i_slot     entry index, 0..17
//   i_wr       data written to entry i_slot on cen edge
//   o_rd       current contents of entry i_slot
module jtopl_eg_ring
  import jtopl_eg_pkg::*;
#(
  parameter int           W       = 10,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cen,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [W-1:0]      i_wr,
  output logic [W-1:0]      o_rd
);

  logic [W-1:0] r_mem [SLOT_NUM];

  // One register per entry with its own decoded write enable.
  for (genvar gi = 0; gi < SLOT_NUM; gi++) begin : g_ent
    logic w_we;
    assign w_we = i_cen && (i_slot == SLOT_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_mem[gi] <= RST_VAL;
      else if (w_we) r_mem[gi] <= i_wr;
    end
  end

  // Guard keeps the read in range even though i_slot never exceeds 17.
  assign o_rd = (i_slot <= SLOT_LAST) ? r_mem[i_slot] : RST_VAL;

endmodule

// File: rtl/jtopl_eg_seq.sv
// jtopl_eg_seq
// Envelope-generator slot sequencer: walks the 18 operator slots, keeps
// the global envelope counter, detects key-on/key-off edges per slot and
// stores the per-slot envelope state and attenuation.
// Ports:
//   clk, rst, cen            clock, async active-high reset, clock enable
//   keyon_in                 key-on bit of the current slot
//   state_wr, eg_wr          next state / attenuation for the current slot
//   slot, zero               current slot (0..17), high at slot 0
//   keyon_now, keyoff_now    key edge flags for the current slot
//   state_rd, eg_rd          stored state / attenuation of the current slot
//   eg_cnt                   global envelope counter (+1 per full slot round)
//   cnt_load, cnt_val        counter preload, only with JTOPL_EG_CNT_LOAD_EN
// Build option: define JTOPL_EG_CNT_LOAD_EN to add the counter preload.
module jtopl_eg_seq
  import jtopl_eg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
`ifdef JTOPL_EG_CNT_LOAD_EN
  input  logic             cnt_load,
  input  logic [CNT_W-1:0] cnt_val,
`endif
  input  logic             keyon_in,
  input  logic [ST_W-1:0]  state_wr,
  input  logic [EG_W-1:0]  eg_wr,
  output logic [SLOT_W-1:0] slot,
  output logic             zero,
  output logic             keyon_now,
  output logic             keyoff_now,
  output logic [ST_W-1:0]  state_rd,
  output logic [EG_W-1:0]  eg_rd,
  output logic [CNT_W-1:0] eg_cnt
);

  logic [SLOT_W-1:0]   r_slot;
  logic [CNT_W-1:0]    r_eg_cnt;
  logic [SLOT_NUM-1:0] r_kon_prev;

  logic                w_kon_prev;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // ---------------- slot counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_slot <= '0;
    else if (cen) r_slot <= slot_next(r_slot);
  end

  // ---------------- envelope counter ----------------
  // Increments on the edge that closes a full slot round (17 -> 0).
  always_comb begin
    w_cnt_nxt = r_eg_cnt;
    if (r_slot == SLOT_LAST) w_cnt_nxt = r_eg_cnt + 15'd1;
`ifdef JTOPL_EG_CNT_LOAD_EN
    if (cnt_load) w_cnt_nxt = cnt_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_eg_cnt <= '0;
    else if (cen) r_eg_cnt <= w_cnt_nxt;
  end

  // ---------------- key edge detect ----------------
  // kon_prev[n] holds keyon_in as last sampled while slot n was current.
  for (genvar gi = 0; gi < SLOT_NUM; gi++) begin : g_kon
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_kon_prev[gi] <= 1'b0;
      else if (cen && r_slot == SLOT_W'(gi))      r_kon_prev[gi] <= keyon_in;
    end
  end

  assign w_kon_prev = (r_slot <= SLOT_LAST) ? r_kon_prev[r_slot] : 1'b0;
  assign keyon_now  =  keyon_in & ~w_kon_prev;
  assign keyoff_now = ~keyon_in &  w_kon_prev;

  // ---------------- per-slot storage ----------------
  jtopl_eg_ring #(
    .W       (ST_W),
    .RST_VAL (RELEASE)
  ) u_state_ring (
    .clk    (clk),
    .rst    (rst),
    .i_cen  (cen),
    .i_slot (r_slot),
    .i_wr   (state_wr),
    .o_rd   (state_rd)
  );

  jtopl_eg_ring #(
    .W       (EG_W),
    .RST_VAL (EG_MAX)
  ) u_eg_ring (
    .clk    (clk),
    .rst    (rst),
    .i_cen  (cen),
    .i_slot (r_slot),
    .i_wr   (eg_wr),
    .o_rd   (eg_rd)
  );

  assign slot   = r_slot;
  assign zero   = (r_slot == '0);
  assign eg_cnt = r_eg_cnt;

endmodule

// File: tb/tb_jtopl_eg_seq.sv
module tb_jtopl_eg_seq;
  import jtopl_eg_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cen, keyon_in;
  logic [2:0]  state_wr;
  logic [9:0]  eg_wr;
  logic        cnt_load = 1'b0;
  logic [14:0] cnt_val  = '0;
  logic [4:0]  slot;
  logic        zero, keyon_now, keyoff_now;
  logic [2:0]  state_rd;
  logic [9:0]  eg_rd;
  logic [14:0] eg_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int ex_slot = 0;
  int ex_cnt  = 0;

  always #5 clk = ~clk;

  jtopl_eg_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
`ifdef JTOPL_EG_CNT_LOAD_EN
    .cnt_load   (cnt_load),
    .cnt_val    (cnt_val),
`endif
    .keyon_in   (keyon_in),
    .state_wr   (state_wr),
    .eg_wr      (eg_wr),
    .slot       (slot),
    .zero       (zero),
    .keyon_now  (keyon_now),
    .keyoff_now (keyoff_now),
    .state_rd   (state_rd),
    .eg_rd      (eg_rd),
    .eg_cnt     (eg_cnt)
  );

  typedef struct {
    logic        keyon;
    logic [2:0]  st_wr;
    logic [9:0]  eg_wr;
    logic [4:0]  e_slot;
    logic        e_zero, e_kon, e_koff;
    logic [2:0]  e_st;
    logic [9:0]  e_eg;
    logic [14:0] e_cnt;
  } vec_t;

  localparam int NV = 72;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One cen-qualified clock edge; returns at posedge+1. ex_* track the
  // expected slot/counter for the hand-written sequences.
  task automatic do_step();
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
    if (cnt_load)          ex_cnt = int'(cnt_val);
    else if (ex_slot == 17) ex_cnt = (ex_cnt + 1) % 32768;
    ex_slot = (ex_slot == 17) ? 0 : ex_slot + 1;
  endtask

  task automatic defaults();
    keyon_in = 1'b0;
    state_wr = RELEASE;
    eg_wr    = 10'h3FF;
  endtask

  task automatic chk_rd(input string nm, input logic [2:0] st, input logic [9:0] eg);
    chk({nm, " state_rd"}, 32'(state_rd), 32'(st));
    chk({nm, " eg_rd"},    32'(eg_rd),    32'(eg));
  endtask

  initial begin
    // Baseline: rings left at reset values, no key activity.
    for (int i = 0; i < NV; i++) begin
      tbl[i].keyon  = 1'b0;
      tbl[i].st_wr  = RELEASE;
      tbl[i].eg_wr  = 10'h3FF;
      tbl[i].e_slot = 5'(i % 18);
      tbl[i].e_zero = (i % 18) == 0;
      tbl[i].e_kon  = 1'b0;
      tbl[i].e_koff = 1'b0;
      tbl[i].e_st   = RELEASE;
      tbl[i].e_eg   = 10'h3FF;
      tbl[i].e_cnt  = 15'(i / 18);
    end
    // Slot 5 key: on (edge), on (held), off (edge), off (held).
    tbl[5].keyon  = 1'b1;  tbl[5].e_kon   = 1'b1;
    tbl[23].keyon = 1'b1;
    tbl[41].e_koff = 1'b1;
    // Slot 3: write ATTACK/000, keep it one round, then restore.
    tbl[3].st_wr  = ATTACK; tbl[3].eg_wr  = 10'h000;
    tbl[21].st_wr = ATTACK; tbl[21].eg_wr = 10'h000;
    tbl[21].e_st  = ATTACK; tbl[21].e_eg  = 10'h000;
    tbl[39].e_st  = ATTACK; tbl[39].e_eg  = 10'h000;

    // ---- reset state ----
    rst = 1'b1; cen = 1'b0; defaults(); keyon_in = 1'b1;
    #2;
    chk("rst slot", 32'(slot), 0);
    chk("rst zero", 32'(zero), 1);
    chk("rst keyon_now", 32'(keyon_now), 1);
    chk("rst keyoff_now", 32'(keyoff_now), 0);
    chk("rst eg_cnt", 32'(eg_cnt), 0);
    chk_rd("rst", RELEASE, 10'h3FF);
    @(posedge clk); #1;
    rst = 1'b0; defaults();

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      keyon_in = tbl[i].keyon;
      state_wr = tbl[i].st_wr;
      eg_wr    = tbl[i].eg_wr;
      #1;
      chk($sformatf("v%0d slot", i),   32'(slot),       32'(tbl[i].e_slot));
      chk($sformatf("v%0d zero", i),   32'(zero),       32'(tbl[i].e_zero));
      chk($sformatf("v%0d kon", i),    32'(keyon_now),  32'(tbl[i].e_kon));
      chk($sformatf("v%0d koff", i),   32'(keyoff_now), 32'(tbl[i].e_koff));
      chk($sformatf("v%0d state", i),  32'(state_rd),   32'(tbl[i].e_st));
      chk($sformatf("v%0d eg", i),     32'(eg_rd),      32'(tbl[i].e_eg));
      chk($sformatf("v%0d cnt", i),    32'(eg_cnt),     32'(tbl[i].e_cnt));
      do_step();
    end
    defaults();

    // ---- cen low holds everything ----
    state_wr = DECAY; eg_wr = 10'h155;
    do_step();
    defaults();
    repeat (17) do_step();
    chk("hold pre slot", 32'(slot), 32'(ex_slot));
    chk("hold pre cnt", 32'(eg_cnt), 32'(ex_cnt));
    chk_rd("hold pre", DECAY, 10'h155);
    state_wr = HOLD; eg_wr = 10'h2AA; keyon_in = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("hold slot", 32'(slot), 0);
    chk("hold cnt", 32'(eg_cnt), 5);
    chk_rd("hold", DECAY, 10'h155);
    defaults();

    // ---- keyon glitch between cen edges is not sampled ----
    repeat (5) do_step();
    chk("glitch slot", 32'(slot), 5);
    keyon_in = 1'b1; #1;
    chk("glitch kon", 32'(keyon_now), 1);
    @(posedge clk); #1;
    keyon_in = 1'b0;
    do_step();
    repeat (17) do_step();
    keyon_in = 1'b1; #1;
    chk("glitch kon again", 32'(keyon_now), 1);
    keyon_in = 1'b0; #1;
    chk("glitch koff", 32'(keyoff_now), 0);

    // ---- async reset mid-sequence ----
    do_step();                                   // slot 5 -> 6
    do_step();                                   // slot 6 -> 7
    state_wr = ATTACK; eg_wr = 10'h011;
    do_step();                                   // write slot 7
    defaults();
    for (int k = 0; k < 10000 && !(ex_slot == 11 && ex_cnt == 'h123); k++) do_step();
    chk("pre-rst slot", 32'(slot), 11);
    chk("pre-rst cnt", 32'(eg_cnt), 32'h123);
    state_wr = HOLD; eg_wr = 10'h2AA; keyon_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst slot", 32'(slot), 0);
    chk("arst cnt", 32'(eg_cnt), 0);
    chk("arst zero", 32'(zero), 1);
    chk("arst kon", 32'(keyon_now), 1);
    chk("arst koff", 32'(keyoff_now), 0);
    chk_rd("arst", RELEASE, 10'h3FF);
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    chk("arst cen slot", 32'(slot), 0);
    chk_rd("arst cen", RELEASE, 10'h3FF);
    rst = 1'b0;
    ex_slot = 0; ex_cnt = 0;
    state_wr = HOLD; eg_wr = 10'h0AB; keyon_in = 1'b0;
    do_step();
    defaults();
    chk("post-rst slot", 32'(slot), 1);
    repeat (6) do_step();
    chk("post-rst slot7", 32'(slot), 7);
    chk_rd("post-rst slot7", RELEASE, 10'h3FF);
    repeat (11) do_step();
    chk("post-rst slot0", 32'(slot), 0);
    chk("post-rst cnt", 32'(eg_cnt), 1);
    chk_rd("post-rst slot0", HOLD, 10'h0AB);

`ifdef JTOPL_EG_CNT_LOAD_EN
    // ---- counter preload and 0x7FFF wrap ----
    for (int k = 0; k < 18 && ex_slot != 17; k++) do_step();
    cnt_load = 1'b1; cnt_val = 15'h7FFF;
    do_step();
    cnt_load = 1'b0;
    chk("load cnt", 32'(eg_cnt), 32'h7FFF);
    chk("load slot", 32'(slot), 0);
    repeat (18) do_step();
    chk("wrap cnt", 32'(eg_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtopl_eg_seq.md
JTOPL_EG_SEQ -- requirements
Module: jtopl_eg_seq

Interface
REQ-001 SHALL have ports clk, rst, cen (in, 1 each); one clock; reset is asynchronous and active-high.
REQ-002 keyon_in  in  1  key-on register bit of the slot currently addressed.
REQ-003 state_wr  in  3  next envelope state from the EG datapath for the current slot.
REQ-004 eg_wr  in  10  next attenuation from the EG datapath for the current slot.
REQ-005 slot  out  5  current operator slot, 0..17.
REQ-006 zero  out  1  high while slot==0.
REQ-007 keyon_now / keyoff_now  out  1 each  key edge flags for the current slot.
REQ-008 state_rd  out  3  stored envelope state of the current slot.
REQ-009 eg_rd  out  10  stored attenuation of the current slot.
REQ-010 eg_cnt  out  15  global envelope counter.

Function
REQ-011 All state SHALL advance only on clk rising edges with cen=1; with cen=0, registers and outputs SHALL hold.
REQ-012 slot SHALL count 0,1,...,17,0; 17 SHALL wrap to 0; values 18..31 SHALL never appear.
REQ-013 eg_cnt SHALL increment by 1 on the cen edge where slot goes 17->0; 0x7FFF SHALL wrap to 0x0000.
REQ-014 An 18-bit kon_prev register SHALL hold the last sampled keyon_in per slot.
REQ-015 keyon_now = keyon_in & ~kon_prev[slot]; keyoff_now = ~keyon_in & kon_prev[slot]; both combinational; never both high.
REQ-016 On each cen edge kon_prev[slot] SHALL load keyon_in.
REQ-017 state_rd/eg_rd SHALL be combinational reads of 18-entry rings (3 bit, 10 bit) at index slot.
REQ-018 On each cen edge the entry at index slot SHALL load state_wr and eg_wr (read-modify-write within one cen period, zero latency).
REQ-019 keyon_in toggling within a slot period SHALL have effect only as sampled at the cen edge.
REQ-020 Ring and kon_prev contents of slots other than slot SHALL be untouched on a cen edge.

Reset
REQ-021 rst=1 SHALL immediately, asynchronously force slot=0, eg_cnt=0, kon_prev=0, every state entry=RELEASE, every eg entry=10'h3FF.
REQ-022 Consequently during and after reset: zero=1, keyon_now=keyon_in, keyoff_now=0, state_rd=RELEASE, eg_rd=10'h3FF.
REQ-023 Reset asserted mid-sequence SHALL discard pending writes; first cen edge after release SHALL process slot 0.

Configuration
REQ-024 Macro JTOPL_EG_CNT_LOAD_EN SHALL, when defined, add inputs cnt_load (1) and cnt_val (15).
REQ-025 With macro defined: cnt_load=1 on a cen edge SHALL load eg_cnt=cnt_val, overriding the REQ-013 increment.
REQ-026 Without the macro: ports SHALL be absent; eg_cnt SHALL follow REQ-013 only.

Structure
REQ-027 Shared package jtopl_eg_pkg SHALL hold state encodings (ATTACK 3'b001, DECAY 3'b010, HOLD 3'b100, RELEASE 3'b000), SLOT_NUM=18, EG_MAX=10'h3FF.
REQ-028 One sub-module jtopl_eg_ring SHALL implement a parameterised-width, 18-entry, async-reset ring indexed by slot; instantiated twice (width 3, width 10).
REQ-029 Slot counter, eg_cnt and kon_prev SHALL live in the top module.

Verification
REQ-030 Reset, then 36 cen pulses -> slot sequence 0..17,0..17; zero high exactly at slots 0; eg_cnt=2.
REQ-031 Preload eg_cnt=0x7FFF via cnt_load (macro on), then 18 cen -> eg_cnt=0x0000.
REQ-032 keyon_in=1 at slot 5 -> keyon_now=1 on first visit, 0 on next visit; keyon_in=0 at slot 5 afterwards -> keyoff_now=1 once.
REQ-033 Write state_wr=ATTACK, eg_wr=10'h000 at slot 3 -> after 18 cen, slot 3 reads ATTACK/0x000; slots 2 and 4 read RELEASE/0x3FF.
REQ-034 cen held 0 for 50 clk -> slot, eg_cnt, and ring outputs unchanged.
REQ-035 Assert rst at slot 11 with eg_cnt=0x0123 -> same cycle slot=0, eg_cnt=0, all entries RELEASE/0x3FF; first cen after release writes slot 0.
